pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 136 +++++++++++++
 tb/tb_pwm_capture.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty code of an incoming PWM line and flags period errors and stuck
// inputs. Define PWM_CAPTURE_FILTER_EN to add a 3-sample glitch filter after the synchroniser.
module pwm_capture #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned PRESCALE    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             valid,
  output logic             period_err,
  output logic             saturated
);
  localparam int unsigned   CW       = WIDTH + PRESCALE + 2;
  localparam logic [CW-1:0] PERIOD   = CW'(1) << (WIDTH + PRESCALE);
  localparam logic [CW-1:0] TIMEOUT  = PERIOD << 1;
  localparam logic [CW-1:0] DUTY_MAX = CW'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   s;
  logic                   s_d_q;
  logic                   rise;
  logic                   fall;
  logic                   timeout;
  state_e                 state_q;
  logic [CW-1:0]          hi_cnt_q;
  logic [CW-1:0]          per_cnt_q;
  logic [CW-1:0]          hi_scaled;
  logic [WIDTH-1:0]       duty_meas;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist_q;
  logic       flt_q;

  // s follows the synchroniser only once the last three samples agree.
  always_comb begin
    s = flt_q;
    if (sync_out == hist_q[0] && sync_out == hist_q[1]) begin
      s = sync_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      flt_q  <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_out};
      flt_q  <= s;
    end
  end
`else
  assign s = sync_out;
`endif

  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign timeout = (per_cnt_q == TIMEOUT);

  always_comb begin
    hi_scaled = hi_cnt_q >> PRESCALE;
    duty_meas = (hi_scaled > DUTY_MAX) ? '1 : hi_scaled[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_d_q      <= 1'b0;
      state_q    <= StIdle;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      duty_out   <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      s_d_q <= s;
      valid <= 1'b0;

      // A rise always restarts the period; a coincident timeout is dropped.
      if (rise) begin
        per_cnt_q <= CW'(1);
        if (state_q == StLow) begin
          valid      <= 1'b1;
          duty_out   <= duty_meas;
          period_err <= (per_cnt_q != PERIOD);
          saturated  <= 1'b0;
        end
      end else if (timeout) begin
        per_cnt_q  <= CW'(1);
        valid      <= 1'b1;
        duty_out   <= {WIDTH{s}};
        period_err <= 1'b0;
        saturated  <= s;
      end else begin
        per_cnt_q <= sat_inc(per_cnt_q);
      end

      case (state_q)
        StIdle, StLow: begin
          if (rise) begin
            hi_cnt_q <= CW'(1);
            state_q  <= StHigh;
          end
        end
        StHigh: begin
          if (fall) begin
            state_q <= StLow;
          end else begin
            hi_cnt_q <= sat_inc(hi_cnt_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: three generator-driven channels plus one hand-driven channel, each
// with its own queue of expected reports.
module tb_pwm_capture;
  typedef struct {
    bit wild;
    int duty;
    int err;
    int sat;
    int at;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       gen_run = 1'b0;
  logic       hand_pwm = 1'b0;
  logic [5:0] gcnt = 6'd63;
  logic [3:0] duty_cmd [4] = '{4'd8, 4'd4, 4'd12, 4'd0};
  logic [3:0] pwm;
  logic [3:0] duty [4];
  logic [3:0] valid;
  logic [3:0] perr;
  logic [3:0] sat;
  int         cyc;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (gen_run) gcnt <= gcnt + 6'd1;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : ch
    exp_t       sb[$];
    bit         armed = 1'b0;
    bit         dirty = 1'b0;
    bit         prev = 1'b0;
    logic [3:0] per_duty = '0;
    logic [3:0] duty_seen = '0;

    if (g == 3) begin : g_hand
      assign pwm[g] = hand_pwm;
    end else begin : g_gen
      assign pwm[g] = gen_run && (gcnt[5:2] < duty_cmd[g]);
    end

    pwm_capture #(
      .WIDTH      (4),
      .PRESCALE   (2),
      .SYNC_STAGES(2)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .pwm_in    (pwm[g]),
      .duty_out  (duty[g]),
      .valid     (valid[g]),
      .period_err(perr[g]),
      .saturated (sat[g])
    );

    // Each generator rise closes a period; push its expected report. A period touched by a
    // duty change or a reset is pushed as a wildcard.
    always @(posedge clk) begin : gen_sb
      bit chg;
      if (reset) begin
        sb.delete();
        armed     <= pwm[g];
        dirty     <= 1'b1;
        prev      <= pwm[g];
        duty_seen <= duty_cmd[g];
      end else if (g < 3) begin
        chg = (duty_cmd[g] != duty_seen);
        duty_seen <= duty_cmd[g];
        prev      <= pwm[g];
        if (chg) dirty <= 1'b1;
        if (pwm[g] && !prev) begin
          if (armed) sb.push_back('{wild: dirty || chg, duty: per_duty, err: 0, sat: 0, at: -1});
          armed    <= 1'b1;
          dirty    <= chg;
          per_duty <= duty_cmd[g];
        end
      end
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (valid[g]) begin
        check($sformatf("ch%0d report_expected", g), sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (!e.wild) begin
            check($sformatf("ch%0d duty_out", g), duty[g], e.duty);
            check($sformatf("ch%0d period_err", g), perr[g], e.err);
            check($sformatf("ch%0d saturated", g), sat[g], e.sat);
          end
          if (e.at >= 0) check($sformatf("ch%0d valid_cycle", g), cyc, e.at);
        end
      end
    end
  end

  task automatic hand_exp(input int d, input int e, input int s, input int at);
    ch[3].sb.push_back('{wild: 1'b0, duty: d, err: e, sat: s, at: at});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_drained(input string when);
    check({"ch0 drained ", when}, ch[0].sb.size(), 0);
    check({"ch1 drained ", when}, ch[1].sb.size(), 0);
    check({"ch2 drained ", when}, ch[2].sb.size(), 0);
    check({"ch3 drained ", when}, ch[3].sb.size(), 0);
  endtask

  initial begin
    #2000;
    duty_cmd[0] = 4'd2;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before 300 us");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ch%0d reset duty_out", i), duty[i], 0);
      check($sformatf("ch%0d reset valid", i), valid[i], 0);
    end
    #16 reset = 1'b0;
    #3 gen_run = 1'b1;

    // Hand channel: stuck low, stuck high, clamp on a long high, 80-cycle periods, stuck low.
    hand_exp(0, 0, 0, 129);
    hand_exp(0, 0, 0, 257);
    wait_cyc(260);
    hand_pwm = 1'b1;
    hand_exp(15, 0, 1, 391);
    hand_exp(15, 0, 1, 519);
    wait_cyc(530);
    hand_pwm = 1'b0;
    wait_cyc(560);
    hand_pwm = 1'b1;
    hand_exp(15, 1, 0, 563);
    wait_cyc(600);
    hand_pwm = 1'b0;
    wait_cyc(640);
    hand_pwm = 1'b1;
    hand_exp(10, 1, 0, 643);
    wait_cyc(680);
    hand_pwm = 1'b0;
    wait_cyc(720);
    hand_pwm = 1'b1;
    hand_exp(10, 1, 0, 723);
    wait_cyc(760);
    hand_pwm = 1'b0;
    hand_exp(0, 0, 0, 851);
    wait_cyc(860);

    // Asynchronous reset in the middle of a high phase on channels 1 and 2.
    while (gcnt != 6'd12) @(negedge clk);
    check_drained("before reset");
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ch%0d async duty_out", i), duty[i], 0);
      check($sformatf("ch%0d async period_err", i), perr[i], 0);
      check($sformatf("ch%0d async saturated", i), sat[i], 0);
      check($sformatf("ch%0d async valid", i), valid[i], 0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hand_exp(0, 0, 0, 129);

    wait_cyc(140);
    while (gcnt != 6'd20) @(negedge clk);
    check_drained("at end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
